adpll_loop_controller: RTL and testbench
========================================

Name: adpll_loop_controller

Overview:
- Digital loop controller between the ADPLL phase detector (UP/DN outputs) and the DCO control input.
- Accumulates UP/DN activity over fixed sample windows and steps a saturating DCO control word.
- Sequences the loop through idle, acquisition (coarse step), tracking (fine step) and locked states, and reports lock status.

Parameters:
- CTRL_W, 8: DCO control word width.
- WIN, 8: sample window length in clk cycles (>=2).
- STEP_ACQ, 4: control word step per window in ACQUIRE.
- STEP_TRK, 1: control word step per window in TRACK and LOCKED.
- LOCK_CNT, 16: consecutive quiet windows in TRACK required to declare lock.
- UNLOCK_CNT, 4: consecutive noisy windows in LOCKED required to drop lock.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  loop enable; 0 forces IDLE.
- UP  in  1  phase detector UP (reference leads).
- DN  in  1  phase detector DN (feedback leads).
- ctrl_word  out  CTRL_W  DCO control word.
- locked  out  1  high only in LOCKED.
- state  out  2  0=IDLE, 1=ACQUIRE, 2=TRACK, 3=LOCKED.

Behaviour:
- Reset values (clk edge with reset=1):
  - ctrl_word = 2^(CTRL_W-1), i.e. 128 for CTRL_W=8.
  - locked = 0, state = IDLE.
  - Window counter, up_cnt, dn_cnt, quiet/noisy counters and last-sign register all 0.
  - Reset asserted mid-window or mid-state takes effect at that edge; the partial window is discarded.
- Per-cycle sampling, in every non-IDLE state:
  - UP=1 and DN=0 increments up_cnt.
  - DN=1 and UP=0 increments dn_cnt.
  - UP=DN=1 or UP=DN=0 increments neither.
- Window timing:
  - Window counter runs 0..WIN-1.
  - The evaluation edge is the edge ending the cycle with count==WIN-1; that cycle's sample is included.
  - At the evaluation edge, the counters clear and the new ctrl_word/state register (latency 0 after the last sample).
- Evaluation:
  - diff = up_cnt - dn_cnt (signed).
  - step = STEP_ACQ in ACQUIRE, STEP_TRK otherwise, using the state before the edge.
  - diff>0: ctrl_word += step, saturating at 2^CTRL_W-1.
  - diff<0: ctrl_word -= step, saturating at 0.
  - diff=0: ctrl_word unchanged.
  - No wrap-around ever.
  - A window is quiet if |diff|<=1, noisy otherwise.
- IDLE:
  - ctrl_word held; no sampling.
  - enable=1 sampled -> ACQUIRE at the next edge; the first sample is taken in the first ACQUIRE cycle.
- ACQUIRE:
  - Tracks sign of last nonzero diff.
  - A window whose diff sign is opposite to the stored sign (overshoot) applies the coarse step, then -> TRACK, quiet counter = 0.
  - diff=0 does not update the stored sign.
- TRACK:
  - Quiet window increments the quiet counter; a noisy window clears it.
  - Quiet counter reaching LOCK_CNT -> LOCKED, noisy counter = 0.
- LOCKED:
  - locked=1; fine steps still applied.
  - Noisy window increments the noisy counter; a quiet window clears it.
  - Noisy counter reaching UNLOCK_CNT -> ACQUIRE, locked=0 at the same edge, stored sign cleared.
- enable=0 in any non-IDLE state:
  - -> IDLE at the next edge; window and sample counters cleared, locked=0, ctrl_word held.
  - Re-enable resumes from the held ctrl_word.
- reset has priority over enable.
- locked is registered and equals (state==LOCKED).

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then enable=0, UP=1 for 32 cycles -> ctrl_word=128, state=0, locked=0 throughout.
- Coarse acquisition: enable=1, UP=1, DN=0 continuously -> state=1 after 1 edge; ctrl_word=132 after 8 sample cycles, 136 after 16, 140 after 24.
- Overshoot: from ctrl_word=140 in ACQUIRE, drive DN=1, UP=0 for one window -> ctrl_word=136, state=2.
- Lock: in TRACK with UP=DN=0 (repeat with UP=DN=1) for 16 windows (128 cycles) -> state=3 and locked=1 at the 16th evaluation edge, ctrl_word unchanged. One window with UP=1 for 3 cycles midway resets the quiet count.
- Unlock: in LOCKED, UP=1 for 4 windows -> ctrl_word +1 per window, state=1 and locked=0 at the 4th evaluation edge. Alternating noisy/quiet windows never unlock.
- Saturation/abort: drive ctrl_word to 255 in ACQUIRE with UP=1 -> stays 255, no wrap (likewise 0 with DN=1). reset=1 at window cycle 5 -> next cycle ctrl_word=128, state=0. enable=0 mid-window -> state=0, ctrl_word held.

Source files
------------

// File: rtl/adpll_loop_controller.sv
// ADPLL digital loop controller: integrates phase-detector UP/DN activity over
// fixed sample windows and steps a saturating DCO control word, sequencing the
// loop through IDLE, ACQUIRE (coarse), TRACK (fine) and LOCKED.
module adpll_loop_controller #(
  parameter int CTRL_W     = 8,
  parameter int WIN        = 8,
  parameter int STEP_ACQ   = 4,
  parameter int STEP_TRK   = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              UP,
  input  logic              DN,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              locked,
  output logic [1:0]        state
);

  localparam int WCNT_W = $clog2(WIN);
  localparam int SCNT_W = $clog2(WIN + 1);
  localparam int DIFF_W = SCNT_W + 1;
  localparam int QCNT_W = $clog2(LOCK_CNT + 1);
  localparam int NCNT_W = $clog2(UNLOCK_CNT + 1);

  localparam logic signed [CTRL_W+1:0] CW_MAX   = {2'b00, {CTRL_W{1'b1}}};
  localparam logic signed [CTRL_W+1:0] CW_MIN   = '0;
  localparam logic        [CTRL_W-1:0] CW_RESET = {1'b1, {(CTRL_W-1){1'b0}}};
  localparam logic signed [DIFF_W-1:0] QUIET_LIM = 1;
  localparam logic signed [DIFF_W-1:0] DIFF_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_TRK  = 2'd2,
    S_LCK  = 2'd3
  } st_t;

  st_t                st;
  logic [WCNT_W-1:0]  win_cnt;
  logic [SCNT_W-1:0]  up_cnt;
  logic [SCNT_W-1:0]  dn_cnt;
  logic [QCNT_W-1:0]  quiet_cnt;
  logic [NCNT_W-1:0]  noisy_cnt;
  logic signed [1:0]  last_sign;   // 0 = none, +1 = ctrl rising, -1 = ctrl falling

  logic               up_s;
  logic               dn_s;
  logic [SCNT_W-1:0]  up_nxt;
  logic [SCNT_W-1:0]  dn_nxt;
  logic signed [DIFF_W-1:0] diff;
  logic signed [1:0]  d_sign;
  logic               quiet;
  logic               win_end;
  logic               overshoot;
  logic [CTRL_W-1:0]  step;

  // Clamp a widened control value into the legal DCO word range.
  function automatic logic [CTRL_W-1:0] sat_ctrl(input logic signed [CTRL_W+1:0] v);
    if (v > CW_MAX) return CW_MAX[CTRL_W-1:0];
    if (v < CW_MIN) return CW_MIN[CTRL_W-1:0];
    return v[CTRL_W-1:0];
  endfunction

  // Move the control word one step in the direction of the window result.
  function automatic logic [CTRL_W-1:0] apply_step(input logic [CTRL_W-1:0] cw,
                                                   input logic signed [1:0] dir,
                                                   input logic [CTRL_W-1:0] stp);
    logic signed [CTRL_W+1:0] base;
    logic signed [CTRL_W+1:0] delta;
    base  = $signed({2'b00, cw});
    delta = $signed({2'b00, stp});
    if (dir == 2'sb01) return sat_ctrl(base + delta);
    if (dir == 2'sb11) return sat_ctrl(base - delta);
    return cw;
  endfunction

  assign up_s    = UP & ~DN;
  assign dn_s    = DN & ~UP;
  assign up_nxt  = up_cnt + {{(SCNT_W-1){1'b0}}, up_s};
  assign dn_nxt  = dn_cnt + {{(SCNT_W-1){1'b0}}, dn_s};
  assign diff    = $signed({1'b0, up_nxt}) - $signed({1'b0, dn_nxt});
  assign quiet   = (diff <= QUIET_LIM) && (diff >= -QUIET_LIM);
  assign win_end = (win_cnt == WCNT_W'(WIN - 1));
  assign step    = (st == S_ACQ) ? CTRL_W'(STEP_ACQ) : CTRL_W'(STEP_TRK);
  assign state   = st;

  // Window result direction, including the sample of the current cycle.
  always_comb begin
    d_sign = 2'sb00;
    if (diff > DIFF_ZERO)      d_sign = 2'sb01;
    else if (diff < DIFF_ZERO) d_sign = 2'sb11;
  end

  // Overshoot: window direction reverses against the last nonzero direction.
  assign overshoot = (last_sign != 2'sb00) && (d_sign != 2'sb00) && (d_sign != last_sign);

  // Loop sequencer, window integration and control word update.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      ctrl_word <= CW_RESET;
      locked    <= 1'b0;
      win_cnt   <= '0;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      quiet_cnt <= '0;
      noisy_cnt <= '0;
      last_sign <= 2'sb00;
    end else if (st == S_IDLE) begin
      if (enable) st <= S_ACQ;
    end else if (!enable) begin
      st        <= S_IDLE;
      locked    <= 1'b0;
      win_cnt   <= '0;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      quiet_cnt <= '0;
      noisy_cnt <= '0;
      last_sign <= 2'sb00;
    end else if (!win_end) begin
      win_cnt <= win_cnt + WCNT_W'(1);
      up_cnt  <= up_nxt;
      dn_cnt  <= dn_nxt;
    end else begin
      win_cnt   <= '0;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      ctrl_word <= apply_step(ctrl_word, d_sign, step);
      case (st)
        S_ACQ: begin
          if (overshoot) begin
            st        <= S_TRK;
            quiet_cnt <= '0;
          end else if (d_sign != 2'sb00) begin
            last_sign <= d_sign;
          end
        end
        S_TRK: begin
          if (!quiet) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QCNT_W'(LOCK_CNT - 1)) begin
            st        <= S_LCK;
            locked    <= 1'b1;
            quiet_cnt <= '0;
            noisy_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + QCNT_W'(1);
          end
        end
        S_LCK: begin
          if (quiet) begin
            noisy_cnt <= '0;
          end else if (noisy_cnt == NCNT_W'(UNLOCK_CNT - 1)) begin
            st        <= S_ACQ;
            locked    <= 1'b0;
            noisy_cnt <= '0;
            last_sign <= 2'sb00;
          end else begin
            noisy_cnt <= noisy_cnt + NCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_loop_controller.sv
// Directed bench for adpll_loop_controller with a scoreboard of expected
// ctrl_word/state/locked triples checked after each stimulus step.
module tb_adpll_loop_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       UP;
  logic       DN;
  logic [7:0] ctrl_word;
  logic       locked;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    c;
    int    s;   // -1: state not checked
    int    l;
  } exp_t;

  exp_t sb[$];

  adpll_loop_controller #(
    .CTRL_W(8), .WIN(8), .STEP_ACQ(4), .STEP_TRK(1), .LOCK_CNT(16), .UNLOCK_CNT(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .UP(UP), .DN(DN),
    .ctrl_word(ctrl_word), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input int c, input int s, input int l);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    e.s   = s;
    e.l   = l;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty got %0d entries expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (int'(ctrl_word) === e.c) else begin
        n_err++;
        $error("FAIL %s ctrl_word got %0d expected %0d", e.tag, ctrl_word, e.c);
      end
      n_vec++;
      assert (int'(locked) === e.l) else begin
        n_err++;
        $error("FAIL %s locked got %0d expected %0d", e.tag, locked, e.l);
      end
      if (e.s >= 0) begin
        n_vec++;
        assert (int'(state) === e.s) else begin
          n_err++;
          $error("FAIL %s state got %0d expected %0d", e.tag, state, e.s);
        end
      end
    end
  endtask

  task automatic step_chk(input string tag, input int n, input int c, input int s, input int l);
    push_exp(tag, c, s, l);
    tick(n);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; UP = 1'b0; DN = 1'b0;
    tick(2);
    push_exp("reset", 128, 0, 0);
    check_out();
    reset = 1'b0;

    // Disabled loop ignores phase detector activity.
    UP = 1'b1;
    for (int i = 0; i < 4; i++) step_chk("idle_hold", 8, 128, 0, 0);

    // Coarse acquisition.
    enable = 1'b1;
    step_chk("acq_entry", 1, 128, 1, 0);
    step_chk("acq_w1", 8, 132, 1, 0);
    step_chk("acq_w2", 8, 136, 1, 0);
    step_chk("acq_w3", 8, 140, 1, 0);

    // Overshoot into tracking.
    UP = 1'b0; DN = 1'b1;
    step_chk("overshoot", 8, 136, 2, 0);

    // Quiet windows, then a noisy one restarts the lock count.
    DN = 1'b0;
    for (int i = 0; i < 5; i++) step_chk("trk_quiet", 8, 136, 2, 0);
    push_exp("trk_noisy", 137, 2, 0);
    UP = 1'b1; tick(3);
    UP = 1'b0; tick(5);
    check_out();

    // Sixteen quiet windows with both inputs high declare lock.
    UP = 1'b1; DN = 1'b1;
    for (int i = 1; i < 16; i++) step_chk("trk_to_lock", 8, 137, 2, 0);
    step_chk("lock", 8, 137, 3, 1);

    // Alternating noisy/quiet windows keep lock; fine steps still applied.
    for (int i = 0; i < 5; i++) begin
      UP = 1'b1; DN = 1'b0;
      step_chk("alt_noisy", 8, 138 + i, 3, 1);
      UP = 1'b0;
      step_chk("alt_quiet", 8, 138 + i, 3, 1);
    end

    // Four consecutive noisy windows drop lock.
    UP = 1'b1;
    for (int i = 1; i < 4; i++) step_chk("unlock_w", 8, 142 + i, 3, 1);
    step_chk("unlock", 8, 146, 1, 0);

    // Coarse steps saturate at the top of the range.
    for (int k = 1; k <= 30; k++)
      step_chk("sat_hi", 8, (146 + 4 * k > 255) ? 255 : 146 + 4 * k, 1, 0);

    // Reset mid-window wins over enable.
    tick(5);
    reset = 1'b1;
    step_chk("rst_mid", 1, 128, 0, 0);
    reset = 1'b0;
    UP = 1'b0; DN = 1'b1;
    step_chk("reacq_entry", 1, 128, 1, 0);
    for (int k = 1; k <= 34; k++)
      step_chk("sat_lo", 8, (128 - 4 * k < 0) ? 0 : 128 - 4 * k, 1, 0);

    // Disable mid-window; the partial window is discarded on re-enable.
    tick(3);
    enable = 1'b0;
    step_chk("disable", 1, 0, 0, 0);
    enable = 1'b1; UP = 1'b1; DN = 1'b0;
    step_chk("reenable", 1, 0, 1, 0);
    step_chk("reen_partial", 5, 0, 1, 0);
    step_chk("reen_full", 3, 4, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
